// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-outstanding memory port between an instruction-fetch
// requester and a data (load/store) requester.
//
// Arbitration: data normally wins a simultaneous request. A saturating
// starvation counter bounds how many data grants in a row can be given while
// a fetch is waiting; once it reaches STARVE_LIMIT the fetch wins.
//
// Each granted command is latched and presented on m_* until m_ack. A
// misaligned data access never reaches memory and completes with d_err.
// A memory that does not answer within MEM_LAT_MAX cycles is abandoned:
// - a data access completes with d_err;
// - a fetch completes with a NOP instruction.
// Completion is a one-cycle ready pulse on the owning port. The read data
// outputs hold their value between pulses.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   if_req/if_addr                fetch request (held until if_ready)
//   if_ready/if_rdata             fetch completion pulse and instruction
//   d_req/d_we/d_funct3/d_addr/d_wdata  data request (held until d_ready)
//   d_ready/d_rdata/d_err         data completion pulse, load data, error
//   m_req/m_we/m_funct3/m_addr/m_wdata  memory command (held until m_ack)
//   m_rdata/m_ack                 memory read data and completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned MEM_LAT_MAX  = 15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_funct3,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [31:0] NOP_INSN  = 32'h0000_0033;  // add x0, x0, x0
  localparam logic [2:0]  FUNCT3_LW = 3'b010;

  localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TC_W = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX + 1) : 1;

  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  // Last busy cycle index before the access is abandoned.
  localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(MEM_LAT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [TC_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             gnt_d_q, gnt_d_d;       // 1: current owner is the data port
  logic             err_q, err_d;           // current transaction ends in error
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             d_misaligned;
  logic             pick_d;
  logic             starving;

  // Alignment check on the requested access width (funct3[1:0] encodes
  // byte/half/word; the sign bit does not matter here).
  always_comb begin
    d_misaligned = 1'b0;
    case (d_funct3[1:0])
      2'b10:   d_misaligned = (d_addr[1:0] != 2'b00);
      2'b01:   d_misaligned = d_addr[0];
      default: d_misaligned = 1'b0;
    endcase
  end

  assign starving = (starve_cnt_q == STARVE_MAX);
  // Data wins unless a fetch is waiting and has already been passed over
  // STARVE_LIMIT times.
  assign pick_d   = d_req && !(if_req && starving);

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    gnt_d_d      = gnt_d_q;
    err_d        = err_q;
    addr_d       = addr_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          tmo_cnt_d = '0;
          err_d     = 1'b0;
          if (pick_d) begin
            gnt_d_d  = 1'b1;
            addr_d   = d_addr;
            we_d     = d_we;
            funct3_d = d_funct3;
            wdata_d  = d_wdata;
            // Only count grants that actually made a fetch wait.
            if (if_req && !starving) begin
              starve_cnt_d = starve_cnt_q + SC_W'(1);
            end
            if (d_misaligned) begin
              // Never reaches memory: complete immediately with an error.
              err_d     = 1'b1;
              d_rdata_d = '0;
              state_d   = RESP;
            end else begin
              state_d   = BUSY_D;
            end
          end else begin
            gnt_d_d      = 1'b0;
            addr_d       = if_addr;
            we_d         = 1'b0;
            funct3_d     = FUNCT3_LW;
            wdata_d      = '0;
            starve_cnt_d = '0;
            state_d      = BUSY_I;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ack) begin
          // An ack in the last allowed cycle still counts as a success.
          state_d   = RESP;
          tmo_cnt_d = '0;
          if (state_q == BUSY_I) begin
            if_rdata_d = m_rdata;
          end else begin
            d_rdata_d  = we_q ? 32'h0 : m_rdata;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = RESP;
          tmo_cnt_d = '0;
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            if_rdata_d = NOP_INSN;
          end else begin
            d_rdata_d  = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TC_W'(1);
        end
      end

      RESP: begin
        // Requests still held here are picked up again from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      gnt_d_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gnt_d_q      <= gnt_d_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs are decoded from registered state only; m_ack never feeds an
  // output combinationally.
  assign m_req    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign m_we     = we_q;
  assign m_funct3 = funct3_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;

  assign if_ready = (state_q == RESP) && !gnt_d_q;
  assign d_ready  = (state_q == RESP) &&  gnt_d_q;
  assign d_err    = d_ready && err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
